// File: rtl/btn_event_pkg.sv
// Shared types and sizes for the button/event arbitration logic.
package btn_event_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  localparam int EVT_CNT_W = 16;
  localparam int N_MAX     = 16;

endpackage

// File: rtl/btn_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last, modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] win,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
    for (int off = N; off >= 1; off--) begin
      idx = IDW'((int'(last) + off) % N);
      if (req[idx]) begin
        win = idx;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Latches one-pulsed active-low events per channel and serialises them onto a
// single valid/ack event channel in round-robin order, flagging overruns.
module btn_event_arbiter
  import btn_event_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic                 clk_op,
  input  logic                 reset_n,
  input  logic [N-1:0]         pulse_n,
  input  logic                 evt_ack,
  output logic                 evt_valid,
  output logic [IDW-1:0]       evt_id,
  output logic [N-1:0]         drop_n,
  output logic                 busy,
  output logic [EVT_CNT_W-1:0] evt_count
);

  if (N < 2 || N > N_MAX) begin : g_bad_n
    $error("btn_event_arbiter: N out of range");
  end

  state_e               state_q, state_d;
  logic [N-1:0]         pending_q, pending_d;
  logic [IDW-1:0]       last_grant_q, last_grant_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [IDW-1:0]       evt_id_q, evt_id_d;
  logic [N-1:0]         drop_n_q, drop_n_d;
  logic [EVT_CNT_W-1:0] evt_count_q, evt_count_d;

  logic [N-1:0]         pulse_set;
  logic [N-1:0]         grant_mask;
  logic [IDW-1:0]       win_idx;
  logic                 any_req;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req  (pending_q),
    .last (last_grant_q),
    .win  (win_idx),
    .any  (any_req)
  );

  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    evt_count_d  = evt_count_q;
    grant_mask   = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_mask  = N'(1) << win_idx;
          evt_id_d    = win_idx;
          evt_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // last_grant moves on acceptance, so an unacked offer never shifts priority.
        if (evt_ack) begin
          evt_valid_d  = 1'b0;
          last_grant_d = evt_id_q;
          evt_count_d  = evt_count_q + EVT_CNT_W'(1);
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new pulse on the edge its channel is granted re-queues the event rather
  // than counting as an overrun; the set term wins over the grant clear.
  always_comb begin
    pulse_set = ~pulse_n;
    pending_d = (pending_q & ~grant_mask) | pulse_set;
    drop_n_d  = ~(pulse_set & pending_q & ~grant_mask);
  end

  always_ff @(posedge clk_op or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      last_grant_q <= IDW'(N - 1);
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      drop_n_q     <= '1;
      evt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      drop_n_q     <= drop_n_d;
      evt_count_q  <= evt_count_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign drop_n    = drop_n_q;
  assign evt_count = evt_count_q;
  assign busy      = (|pending_q) | evt_valid_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: vector table plus corner-case sequences.
module tb_btn_event_arbiter;

  logic        clk_op;
  logic        reset_n;
  logic [3:0]  pulse_n;
  logic        evt_ack;
  logic        evt_valid;
  logic [1:0]  evt_id;
  logic [3:0]  drop_n;
  logic        busy;
  logic [15:0] evt_count;

  int n_vec;
  int n_err;

  btn_event_arbiter #(.N(4), .IDW(2)) dut (
    .clk_op    (clk_op),
    .reset_n   (reset_n),
    .pulse_n   (pulse_n),
    .evt_ack   (evt_ack),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .drop_n    (drop_n),
    .busy      (busy),
    .evt_count (evt_count)
  );

  initial clk_op = 1'b0;
  always #5 clk_op = ~clk_op;

  typedef struct packed {
    logic        rst;
    logic [3:0]  pn;
    logic        ack;
    logic        exp_v;
    logic [1:0]  exp_id;
    logic [3:0]  exp_drop;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] pn, input logic ack,
                              input logic v, input logic [1:0] id, input logic [3:0] drp,
                              input logic bsy, input logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.pn = pn; r.ack = ack; r.exp_v = v; r.exp_id = id;
    r.exp_drop = drp; r.exp_busy = bsy; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] id,
                         input logic [3:0] drp, input logic bsy, input logic [15:0] cnt);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    if (v) chk({tag, ".id"}, 32'(evt_id), 32'(id));
    chk({tag, ".drop_n"}, 32'(drop_n), 32'(drp));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".count"}, 32'(evt_count), 32'(cnt));
  endtask

  task automatic step(input logic [3:0] pn, input logic ack);
    pulse_n = pn;
    evt_ack = ack;
    @(posedge clk_op);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    pulse_n = 4'hF;
    evt_ack = 1'b0;

    // single event, held offer, then ack
    tbl.push_back(mk(0, 4'b1110, 0, 0, 0, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'hF, 0, 16'd1));
    // all four at once after reset, ack held high
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'hF, 1, 16'd1));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 1, 4'hF, 1, 16'd1));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 1, 4'hF, 1, 16'd2));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 2, 4'hF, 1, 16'd2));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 2, 4'hF, 1, 16'd3));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 3, 4'hF, 1, 16'd3));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 3, 4'hF, 0, 16'd4));
    // grant 2, then 1 and 3 together: 3 before 1
    tbl.push_back(mk(0, 4'b1011, 0, 0, 3, 4'hF, 1, 16'd4));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 2, 4'hF, 1, 16'd4));
    tbl.push_back(mk(0, 4'b0101, 0, 1, 2, 4'hF, 1, 16'd4));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 2, 4'hF, 1, 16'd5));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 3, 4'hF, 1, 16'd5));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 3, 4'hF, 1, 16'd6));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 1, 4'hF, 1, 16'd6));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 1, 4'hF, 0, 16'd7));

    // reset state
    repeat (2) @(posedge clk_op);
    #1;
    chk_all("reset", 0, 0, 4'hF, 0, 16'd0);
    chk("reset.id", 32'(evt_id), 32'd0);
    @(negedge clk_op);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      step(tbl[i].pn, tbl[i].ack);
      chk_all($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_id,
              tbl[i].exp_drop, tbl[i].exp_busy, tbl[i].exp_cnt);
    end

    // overrun on channel 1 while channel 0 is held on offer
    step(4'b1100, 0); chk_all("ovr0", 0, 0, 4'hF, 1, 16'd7);
    step(4'b1111, 0); chk_all("ovr1", 1, 0, 4'hF, 1, 16'd7);
    step(4'b1101, 0); chk_all("ovr2", 1, 0, 4'b1101, 1, 16'd7);
    step(4'b1111, 0); chk_all("ovr3", 1, 0, 4'hF, 1, 16'd7);
    step(4'b1101, 0); chk_all("ovr4", 1, 0, 4'b1101, 1, 16'd7);
    step(4'b1111, 1); chk_all("ovr5", 0, 0, 4'hF, 1, 16'd8);
    step(4'b1111, 0); chk_all("ovr6", 1, 1, 4'hF, 1, 16'd8);
    step(4'b1111, 1); chk_all("ovr7", 0, 1, 4'hF, 0, 16'd9);
    step(4'b1111, 0); chk_all("ovr8", 0, 1, 4'hF, 0, 16'd9);

    // pulse on the same edge the channel is granted: re-queued, no drop
    step(4'b1110, 0); chk_all("same0", 0, 0, 4'hF, 1, 16'd9);
    step(4'b1110, 0); chk_all("same1", 1, 0, 4'hF, 1, 16'd9);
    step(4'b1111, 1); chk_all("same2", 0, 0, 4'hF, 1, 16'd10);
    step(4'b1111, 0); chk_all("same3", 1, 0, 4'hF, 1, 16'd10);
    step(4'b1111, 1); chk_all("same4", 0, 0, 4'hF, 0, 16'd11);

    // asynchronous reset in the middle of an offer
    step(4'b0111, 0); chk_all("rst0", 0, 0, 4'hF, 1, 16'd11);
    step(4'b1111, 0); chk_all("rst1", 1, 3, 4'hF, 1, 16'd11);
    step(4'b1011, 0); chk_all("rst2", 1, 3, 4'hF, 1, 16'd11);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst3", 0, 0, 4'hF, 0, 16'd0);
    chk("rst3.id", 32'(evt_id), 32'd0);
    @(negedge clk_op);
    reset_n = 1'b1;

    // counter wrap from 0xFFFF
    step(4'b1111, 0);
    force dut.evt_count_q = 16'hFFFF;
    #1;
    release dut.evt_count_q;
    step(4'b1011, 0); chk_all("wrap0", 0, 0, 4'hF, 1, 16'hFFFF);
    step(4'b1111, 0); chk_all("wrap1", 1, 2, 4'hF, 1, 16'hFFFF);
    step(4'b1111, 1); chk_all("wrap2", 0, 2, 4'hF, 0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
